// File: rtl/display_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : display_sequencer
// Brief    : SCLK/GCLK generation, angular slot tracking and FC/GS shift-latch
//            sequencing for NB_ROW_GROUPS multiplexed LED driver groups.
//            Define SEQ_OVERRUN_CNT_EN to add the saturating overrun_cnt port.
// Revision : 1.0 - initial release
// ============================================================================
module display_sequencer #(
    parameter int SCLK_FACTOR       = 4,
    parameter int GCLK_FACTOR       = 2,
    parameter int CNT_W             = 24,
    parameter int NB_ANGLES         = 128,
    parameter int NB_LEDS_PER_GROUP = 16,
    parameter int NB_ROW_GROUPS     = 4,
    parameter int BIT_DEPTH         = 16,
    parameter int FC_BITS           = 48
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              turn_tick,
    input  logic                                              write_fc,
    input  logic                                              hps_override,
    input  logic                                              hps_SCLK,
    input  logic                                              hps_LAT,
    output logic                                              SCLK,
    output logic                                              GCLK,
    output logic                                              LAT,
    output logic [NB_ROW_GROUPS-1:0]                          row_en,
    output logic [$clog2(NB_LEDS_PER_GROUP)-1:0]              led,
    output logic [1:0]                                        color,
    output logic [$clog2(BIT_DEPTH)-1:0]                      bit_sel,
    output logic [$clog2(NB_LEDS_PER_GROUP*NB_ROW_GROUPS)-1:0] led_row,
    output logic [$clog2(NB_ANGLES)-1:0]                      angle,
    output logic                                              busy,
    output logic                                              overrun
`ifdef SEQ_OVERRUN_CNT_EN
    ,
    output logic [15:0]                                       overrun_cnt
`endif
);

    localparam int c_SC_W   = $clog2(SCLK_FACTOR);
    localparam int c_GC_W   = $clog2(GCLK_FACTOR);
    localparam int c_LED_W  = $clog2(NB_LEDS_PER_GROUP);
    localparam int c_GRP_W  = (NB_ROW_GROUPS > 1) ? $clog2(NB_ROW_GROUPS) : 1;
    localparam int c_BIT_W  = $clog2(BIT_DEPTH);
    localparam int c_LROW_W = $clog2(NB_LEDS_PER_GROUP*NB_ROW_GROUPS);
    localparam int c_ANG_W  = $clog2(NB_ANGLES);
    localparam int c_SEQ_W  = $clog2((FC_BITS > 5) ? FC_BITS : 5);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_FC_SHIFT = 3'd1;
    localparam logic [2:0] c_ST_FC_LAT   = 3'd2;
    localparam logic [2:0] c_ST_GS_SHIFT = 3'd3;
    localparam logic [2:0] c_ST_GS_WRT   = 3'd4;
    localparam logic [2:0] c_ST_GS_LATG  = 3'd5;

    // ---------------- clock dividers ----------------
    logic [c_SC_W-1:0] r_sclk_cnt, w_sclk_cnt_nxt;
    logic [c_GC_W-1:0] r_gclk_cnt, w_gclk_cnt_nxt;
    logic              r_sclk_gen, r_gclk_gen, w_sclk_gen_nxt, w_sclk_fall;

    assign w_sclk_cnt_nxt = (r_sclk_cnt == c_SC_W'(SCLK_FACTOR-1)) ? '0 : r_sclk_cnt + 1'b1;
    assign w_gclk_cnt_nxt = (r_gclk_cnt == c_GC_W'(GCLK_FACTOR-1)) ? '0 : r_gclk_cnt + 1'b1;
    assign w_sclk_gen_nxt = (w_sclk_cnt_nxt < c_SC_W'(SCLK_FACTOR/2));
    assign w_sclk_fall    = r_sclk_gen && !w_sclk_gen_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_cnt <= '0;
            r_gclk_cnt <= '0;
            r_sclk_gen <= 1'b0;
            r_gclk_gen <= 1'b0;
        end else begin
            r_sclk_cnt <= w_sclk_cnt_nxt;
            r_gclk_cnt <= w_gclk_cnt_nxt;
            r_sclk_gen <= w_sclk_gen_nxt;
            r_gclk_gen <= (w_gclk_cnt_nxt < c_GC_W'(GCLK_FACTOR/2));
        end
    end

    // ---------------- angular slot tracking ----------------
    // The tick cycle itself belongs to the turn it closes, hence the
    // saturating increment is what gets divided into slot_len.
    logic [CNT_W-1:0]   r_period, r_slot_len, r_slot_cnt, w_period_inc;
    logic [c_ANG_W-1:0] r_angle, w_angle_nxt;
    logic               w_slot_end, w_angle_chg;

    assign w_period_inc = (&r_period) ? r_period : r_period + 1'b1;
    assign w_slot_end   = (r_slot_len != '0) && (r_slot_cnt == r_slot_len - 1'b1);
    assign w_angle_chg  = (w_angle_nxt != r_angle);

    always_comb begin
        w_angle_nxt = r_angle;
        if (turn_tick)
            w_angle_nxt = '0;
        else if (w_slot_end && (r_angle != c_ANG_W'(NB_ANGLES-1)))
            w_angle_nxt = r_angle + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_period   <= '0;
            r_slot_len <= '0;
            r_slot_cnt <= '0;
            r_angle    <= '0;
        end else begin
            r_angle <= w_angle_nxt;
            if (turn_tick) begin
                r_period   <= '0;
                r_slot_len <= w_period_inc >> c_ANG_W;
                r_slot_cnt <= '0;
            end else begin
                r_period <= w_period_inc;
                if (r_slot_len != '0)
                    r_slot_cnt <= w_slot_end ? '0 : r_slot_cnt + 1'b1;
            end
        end
    end

    // ---------------- sequencer FSM ----------------
    logic [2:0]           r_state, w_state_nxt;
    logic [c_SEQ_W-1:0]   r_seq, w_seq_nxt;
    logic [c_GRP_W-1:0]   r_group, w_group_nxt;
    logic [c_LED_W-1:0]   r_led, w_led_nxt;
    logic [1:0]           r_color, w_color_nxt;
    logic [c_BIT_W-1:0]   r_bit, w_bit_nxt;
    logic                 r_fc_pend, r_angle_pend, r_overrun;
    logic                 r_sclk_out, r_lat_out;
    logic                 w_idle_slot, w_accept_fc, w_accept_gs, w_gs_active, w_overrun_evt;

    assign w_idle_slot   = w_sclk_fall && !hps_override && (r_state == c_ST_IDLE);
    assign w_accept_fc   = w_idle_slot && r_fc_pend;
    assign w_accept_gs   = w_idle_slot && !r_fc_pend && r_angle_pend;
    assign w_gs_active   = (r_state == c_ST_GS_SHIFT) || (r_state == c_ST_GS_WRT) ||
                           (r_state == c_ST_GS_LATG);
    assign w_overrun_evt = !hps_override && w_angle_chg && (r_angle_pend || w_gs_active);

    always_comb begin
        w_state_nxt = r_state;
        w_seq_nxt   = r_seq;
        w_group_nxt = r_group;
        w_led_nxt   = r_led;
        w_color_nxt = r_color;
        w_bit_nxt   = r_bit;
        if (hps_override) begin
            w_state_nxt = c_ST_IDLE;
            w_seq_nxt   = '0;
            w_group_nxt = '0;
            w_led_nxt   = '0;
            w_color_nxt = '0;
            w_bit_nxt   = '0;
        end else if (w_sclk_fall) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (r_fc_pend) begin
                        w_state_nxt = c_ST_FC_SHIFT;
                        w_seq_nxt   = '0;
                    end else if (r_angle_pend) begin
                        w_state_nxt = c_ST_GS_SHIFT;
                        w_group_nxt = '0;
                        w_led_nxt   = '0;
                        w_color_nxt = '0;
                        w_bit_nxt   = c_BIT_W'(BIT_DEPTH-1);
                    end
                end
                c_ST_FC_SHIFT: begin
                    if (r_seq == c_SEQ_W'(FC_BITS-1)) begin
                        w_state_nxt = c_ST_FC_LAT;
                        w_seq_nxt   = '0;
                    end else begin
                        w_seq_nxt = r_seq + 1'b1;
                    end
                end
                c_ST_FC_LAT: begin
                    if (r_seq == c_SEQ_W'(4)) begin
                        w_state_nxt = c_ST_IDLE;
                        w_seq_nxt   = '0;
                    end else begin
                        w_seq_nxt = r_seq + 1'b1;
                    end
                end
                c_ST_GS_SHIFT: begin
                    // bit is the fastest index, colour next, then the LED
                    if (r_bit != '0) begin
                        w_bit_nxt = r_bit - 1'b1;
                    end else begin
                        w_bit_nxt = c_BIT_W'(BIT_DEPTH-1);
                        if (r_color != 2'd2) begin
                            w_color_nxt = r_color + 2'd1;
                        end else begin
                            w_color_nxt = '0;
                            w_seq_nxt   = '0;
                            w_state_nxt = (r_led == c_LED_W'(NB_LEDS_PER_GROUP-1)) ?
                                          c_ST_GS_LATG : c_ST_GS_WRT;
                        end
                    end
                end
                c_ST_GS_WRT: begin
                    w_state_nxt = c_ST_GS_SHIFT;
                    w_led_nxt   = r_led + 1'b1;
                end
                c_ST_GS_LATG: begin
                    if (r_seq == c_SEQ_W'(2)) begin
                        w_seq_nxt = '0;
                        w_led_nxt = '0;
                        if (r_group == c_GRP_W'(NB_ROW_GROUPS-1)) begin
                            w_state_nxt = c_ST_IDLE;
                            w_group_nxt = '0;
                        end else begin
                            w_state_nxt = c_ST_GS_SHIFT;
                            w_group_nxt = r_group + 1'b1;
                        end
                    end else begin
                        w_seq_nxt = r_seq + 1'b1;
                    end
                end
                default: w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_seq        <= '0;
            r_group      <= '0;
            r_led        <= '0;
            r_color      <= '0;
            r_bit        <= '0;
            r_fc_pend    <= 1'b0;
            r_angle_pend <= 1'b0;
            r_overrun    <= 1'b0;
            r_sclk_out   <= 1'b0;
            r_lat_out    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_seq      <= w_seq_nxt;
            r_group    <= w_group_nxt;
            r_led      <= w_led_nxt;
            r_color    <= w_color_nxt;
            r_bit      <= w_bit_nxt;
            // registered so the gated shift clock cannot glitch on state entry
            r_sclk_out <= w_sclk_gen_nxt &&
                          ((w_state_nxt == c_ST_FC_SHIFT) || (w_state_nxt == c_ST_GS_SHIFT));
            r_lat_out  <= (w_state_nxt == c_ST_FC_LAT) || (w_state_nxt == c_ST_GS_WRT) ||
                          (w_state_nxt == c_ST_GS_LATG);
            if (hps_override) begin
                r_fc_pend    <= 1'b0;
                r_angle_pend <= 1'b0;
            end else begin
                r_fc_pend    <= write_fc || (r_fc_pend && !w_accept_fc);
                r_angle_pend <= w_angle_chg || (r_angle_pend && !w_accept_gs);
            end
            if (w_overrun_evt)
                r_overrun <= 1'b1;
        end
    end

`ifdef SEQ_OVERRUN_CNT_EN
    logic [15:0] r_ovr_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ovr_cnt <= '0;
        else if (w_overrun_evt && (r_ovr_cnt != 16'hFFFF))
            r_ovr_cnt <= r_ovr_cnt + 16'd1;
    end

    assign overrun_cnt = r_ovr_cnt;
`endif

    // ---------------- outputs ----------------
    assign SCLK    = hps_override ? hps_SCLK : r_sclk_out;
    assign LAT     = hps_override ? hps_LAT  : r_lat_out;
    assign GCLK    = r_gclk_gen;
    assign row_en  = NB_ROW_GROUPS'(1) << r_group;
    assign led     = r_led;
    assign color   = r_color;
    assign bit_sel = r_bit;
    assign led_row = c_LROW_W'(r_led) * c_LROW_W'(NB_ROW_GROUPS) + c_LROW_W'(r_group);
    assign angle   = r_angle;
    assign busy    = (r_state != c_ST_IDLE);
    assign overrun = r_overrun;

endmodule

`default_nettype wire
